// File: rtl/odd_parity_serial_tx.sv
// odd_parity_serial_tx
//   Serial transmitter producing odd-parity frames:
//     start(0), DATA_W data bits LSB first, parity, stop(1).
//   Each serial bit is held for CLKS_PER_BIT clocks. The parity bit is chosen
//   so that the data bits plus parity contain an odd number of ones.
//
// Ports
//   clk        : rising-edge clock
//   rst        : asynchronous, active-high reset
//   in_data    : word to transmit, sampled only on the accept edge
//   in_valid   : in_data is valid
//   in_ready   : block can accept a word (registered, high only in IDLE)
//   tx         : serial line, idles high (registered)
//   busy       : frame in progress, always ~in_ready
//   parity_bit : ~(^word) of the last accepted word, held until next accept
module odd_parity_serial_tx #(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              parity_bit
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               parity_q, parity_d;
  logic               tx_q, tx_d;
  logic               rdy_q, rdy_d;
  logic               bit_end;

  function automatic logic odd_parity(input logic [DATA_W-1:0] d);
    return ~(^d);
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    bit_end  = (cnt_q == CNT_LAST);

    // The bit-period counter only runs while a frame is on the line.
    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d  = START;
          shift_d  = in_data;
          parity_d = odd_parity(in_data);
          cnt_d    = '0;
          idx_d    = '0;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_LAST) begin
            state_d = PARITY;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // tx and in_ready are computed from the next state and registered, so
    // the outputs come straight from flops with no path from in_valid.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_d;
      default: tx_d = 1'b1;
    endcase
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      rdy_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      rdy_q    <= rdy_d;
    end
  end

  // Payload register needs no reset: it is always reloaded on accept.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign in_ready   = rdy_q;
  assign busy       = ~rdy_q;
  assign tx         = tx_q;
  assign parity_bit = parity_q;

endmodule

// File: tb/tb_odd_parity_serial_tx.sv
module tb_odd_parity_serial_tx;

  logic       clk;
  logic       rst;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic       parity_bit;

  int checks;
  int failures;

  odd_parity_serial_tx #(
    .DATA_W      (4),
    .CLKS_PER_BIT(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .tx        (tx),
    .busy      (busy),
    .parity_bit(parity_bit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected line level for serial bit b (0=start, 1..4=data, 5=parity, 6=stop).
  function automatic logic frame_bit(input logic [3:0] w, input logic par, input int b);
    if (b == 0) return 1'b0;
    if (b <= 4) return w[b-1];
    if (b == 5) return par;
    return 1'b1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 200 && !in_ready; i++) step();
    chk1("wait_ready", in_ready, 1'b1);
  endtask

  // Accept one word, then check every cycle of the 28-cycle frame and the
  // return to idle. in_data is scrambled after the accept edge.
  task automatic send_frame(input logic [3:0] w, input logic par);
    wait_ready();
    in_data  = w;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_data  = ~w;
    chk1("parity_bit", parity_bit, par);
    for (int pos = 0; pos < 28; pos++) begin
      chk1("frame_tx", tx, frame_bit(w, par, pos / 4));
      chk1("frame_not_ready", in_ready, 1'b0);
      if (pos % 4 == 0) chk1("frame_busy", busy, 1'b1);
      step();
    end
    chk1("end_ready", in_ready, 1'b1);
    chk1("end_tx_idle", tx, 1'b1);
    chk1("end_busy", busy, 1'b0);
    chk1("parity_held", parity_bit, par);
  endtask

  logic [3:0] acc_word;
  logic [3:0] d_b;
  logic       rdy_b;
  logic [6:0] bits;
  int         pos;
  int         nacc;
  int         acc_cyc;

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 4'h0;

    // Reset values
    #1;
    chk1("rst_tx", tx, 1'b1);
    chk1("rst_ready", in_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_parity", parity_bit, 1'b0);
    step();
    rst = 1'b0;
    step();

    // Directed frames
    send_frame(4'b0000, 1'b1);
    send_frame(4'b1010, 1'b1);
    send_frame(4'b0111, 1'b0);

    // Streaming: in_valid held high, in_data changing every cycle
    wait_ready();
    in_valid = 1'b1;
    pos      = -1;
    nacc     = 0;
    acc_cyc  = 0;
    acc_word = 4'h0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      in_data = 4'(cyc * 7 + 3);
      rdy_b   = in_ready;
      d_b     = in_data;
      step();
      if (rdy_b) begin
        if (nacc > 0) chkw("stream_gap", cyc - acc_cyc, 29);
        acc_cyc  = cyc;
        acc_word = d_b;
        nacc++;
        pos = 0;
        chk1("stream_parity", parity_bit, ~(^d_b));
      end
      if (pos >= 0 && pos < 28) begin
        chk1("stream_tx", tx, frame_bit(acc_word, ~(^acc_word), pos / 4));
        pos++;
      end else if (pos == 28) begin
        chk1("stream_idle_tx", tx, 1'b1);
        chk1("stream_idle_ready", in_ready, 1'b1);
        pos = 29;
      end
    end
    in_valid = 1'b0;
    chkw("stream_accepts", nacc, 4);

    // Mid-frame reset during the second data bit of 4'b1111
    wait_ready();
    in_data  = 4'b1111;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk1("mr_parity_before", parity_bit, 1'b1);
    for (int i = 0; i < 9; i++) step();
    chk1("mr_busy_before", busy, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    chk1("mr_tx", tx, 1'b1);
    chk1("mr_ready", in_ready, 1'b1);
    chk1("mr_busy", busy, 1'b0);
    chk1("mr_parity", parity_bit, 1'b0);
    step();
    rst = 1'b0;
    step();
    chk1("mr_after_ready", in_ready, 1'b1);
    chk1("mr_after_tx", tx, 1'b1);
    send_frame(4'b0001, 1'b0);

    // Loopback through a bench deserializer, sampling mid-bit
    for (int w = 0; w < 16; w++) begin
      wait_ready();
      in_data  = 4'(w);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      bits = '0;
      for (int p = 0; p < 28; p++) begin
        if (p % 4 == 2) bits[p/4] = tx;
        step();
      end
      chk1("lb_start", bits[0], 1'b0);
      chk1("lb_stop", bits[6], 1'b1);
      chkw("lb_data", int'(bits[4:1]), w);
      chk1("lb_error", ~(^bits[4:1] ^ bits[5]), 1'b0);
      chk1("lb_parity_port", parity_bit, bits[5]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
